invol_arbiter: RTL and testbench

//  Shares the single upstream response/message channel among NUNITS units that raise invol_req for

---
 rtl/invol_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_invol_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/invol_arbiter.sv
// Round-robin arbiter that frames one unit's unsolicited message at a time for the packet encoder.
// Define INVOL_ARBITER_STATS_EN to add saturating stat_msgs / stat_aborts counters.
module invol_arbiter #(
    parameter int NUNITS    = 4,
    parameter int MAX_WORDS = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUNITS-1:0]    invol_req,
    output logic [NUNITS-1:0]    invol_grant,
    input  logic [32*NUNITS-1:0] param_data,
    input  logic [NUNITS-1:0]    param_write,
    input  logic                 cmd_busy,
    input  logic [7:0]           out_space,
    output logic [31:0]          msg_data,
    output logic                 msg_write,
    output logic                 msg_end,
    output logic                 msg_abort
`ifdef INVOL_ARBITER_STATS_EN
    ,
    output logic [15:0]          stat_msgs,
    output logic [15:0]          stat_aborts
`endif
);
    localparam int IDX_W = $clog2(NUNITS);
    localparam int CNT_W = $clog2(MAX_WORDS + 1);
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_WORDS);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [7:0]       SPACE_MIN = 8'(MAX_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [IDX_W-1:0]  sel_q, sel_d;
    logic [NUNITS-1:0] grant_q, grant_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [31:0]       data_q, data_d;
    logic              wr_q, wr_d, end_q, end_d, abort_q, abort_d;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    int                cand;
    logic              sel_req, sel_wr;
    logic [31:0]       sel_data;

    // Scan downward so the candidate closest to rr (at or after it, wrapping) wins last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = NUNITS - 1; k >= 0; k--) begin
            cand = int'(rr_q) + k;
            if (cand >= NUNITS) cand = cand - NUNITS;
            if (invol_req[IDX_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        sel_req  = 1'b0;
        sel_wr   = 1'b0;
        sel_data = '0;
        for (int i = 0; i < NUNITS; i++) begin
            if (sel_q == IDX_W'(i)) begin
                sel_req  = invol_req[i];
                sel_wr   = param_write[i];
                sel_data = param_data[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        count_d = count_q;
        timer_d = timer_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        end_d   = 1'b0;
        abort_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!cmd_busy && (out_space >= SPACE_MIN) && pick_found) begin
                    state_d = S_GRANT;
                    sel_d   = pick_idx;
                    grant_d = {{(NUNITS-1){1'b0}}, 1'b1} << pick_idx;
                    rr_d    = (pick_idx == IDX_W'(NUNITS - 1)) ? '0 : pick_idx + IDX_W'(1);
                    count_d = '0;
                    timer_d = '0;
                end
            end
            S_GRANT: begin
                if (!sel_req) begin
                    end_d   = 1'b1;
                    data_d  = sel_data;
                    grant_d = '0;
                    state_d = S_GAP;
                end else if (sel_wr && (count_q == CNT_MAX)) begin
                    abort_d = 1'b1;
                    grant_d = '0;
                    state_d = S_GAP;
                end else if (timer_q == TMR_LAST) begin
                    abort_d = 1'b1;
                    grant_d = '0;
                    state_d = S_GAP;
                end else if (sel_wr) begin
                    wr_d    = 1'b1;
                    data_d  = sel_data;
                    count_d = count_q + CNT_W'(1);
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            count_q <= '0;
            timer_q <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            end_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            count_q <= count_d;
            timer_q <= timer_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            end_q   <= end_d;
            abort_q <= abort_d;
        end
    end

    assign invol_grant = grant_q;
    assign msg_data    = data_q;
    assign msg_write   = wr_q;
    assign msg_end     = end_q;
    assign msg_abort   = abort_q;

`ifdef INVOL_ARBITER_STATS_EN
    logic [15:0] msgs_q, msgs_d, aborts_q, aborts_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    always_comb begin
        msgs_d   = sat_inc(msgs_q, end_d);
        aborts_d = sat_inc(aborts_q, abort_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msgs_q   <= '0;
            aborts_q <= '0;
        end else begin
            msgs_q   <= msgs_d;
            aborts_q <= aborts_d;
        end
    end

    assign stat_msgs   = msgs_q;
    assign stat_aborts = aborts_q;
`endif
endmodule

// File: tb/tb_invol_arbiter.sv
// Self-checking bench for invol_arbiter: vector table, directed corner sequences, random vs. reference model.
module tb_invol_arbiter;
    localparam int N  = 4;
    localparam int MW = 8;
    localparam int TO = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    invol_req, invol_grant, param_write;
    logic [32*N-1:0] param_data;
    logic            cmd_busy;
    logic [7:0]      out_space;
    logic [31:0]     msg_data;
    logic            msg_write, msg_end, msg_abort;
`ifdef INVOL_ARBITER_STATS_EN
    logic [15:0]     stat_msgs, stat_aborts;
`endif

    invol_arbiter #(.NUNITS(N), .MAX_WORDS(MW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .invol_req(invol_req), .invol_grant(invol_grant),
        .param_data(param_data), .param_write(param_write), .cmd_busy(cmd_busy),
        .out_space(out_space), .msg_data(msg_data), .msg_write(msg_write),
        .msg_end(msg_end), .msg_abort(msg_abort)
`ifdef INVOL_ARBITER_STATS_EN
        , .stat_msgs(stat_msgs), .stat_aborts(stat_aborts)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the channel, the rotating start point, and the cool-down after a message.
    int          m_owner, m_ptr, m_cool, m_words, m_quiet, m_msgs, m_aborts;
    logic [31:0] m_data;
    bit          m_wr, m_end, m_ab;

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_cool = 0; m_words = 0; m_quiet = 0;
        m_msgs = 0; m_aborts = 0; m_data = '0; m_wr = 0; m_end = 0; m_ab = 0;
    endtask

    function automatic logic [31:0] lane(input int u);
        return param_data[32*u +: 32];
    endfunction

    task automatic model_edge();
        m_wr = 0; m_end = 0; m_ab = 0;
        if (m_owner >= 0) begin
            if (!invol_req[m_owner]) begin
                m_end = 1; m_data = lane(m_owner); m_owner = -1; m_cool = 1; m_msgs++;
            end else if ((param_write[m_owner] && m_words == MW) || m_quiet == TO - 1) begin
                m_ab = 1; m_owner = -1; m_cool = 1; m_aborts++;
            end else if (param_write[m_owner]) begin
                m_wr = 1; m_data = lane(m_owner); m_words++; m_quiet = 0;
            end else begin
                m_quiet++;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (!cmd_busy && out_space >= MW && invol_req != '0) begin
            for (int k = 0; k < N; k++) begin
                if (invol_req[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    break;
                end
            end
            m_ptr = (m_owner + 1) % N; m_words = 0; m_quiet = 0;
        end
    endtask

    task automatic step();
        logic [N-1:0] eg;
        @(posedge clk);
        model_edge();
        #1;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        chk("grant", 32'(invol_grant), 32'(eg));
        chk("msg_write", 32'(msg_write), 32'(m_wr));
        chk("msg_end", 32'(msg_end), 32'(m_end));
        chk("msg_abort", 32'(msg_abort), 32'(m_ab));
        chk("msg_data", msg_data, m_data);
`ifdef INVOL_ARBITER_STATS_EN
        chk("stat_msgs", 32'(stat_msgs), 32'(m_msgs));
        chk("stat_aborts", 32'(stat_aborts), 32'(m_aborts));
`endif
    endtask

    task automatic idle_inputs();
        invol_req = '0; param_write = '0; param_data = '0; cmd_busy = 1'b0; out_space = 8'd8;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input string name);
        int n;
        n = 0;
        while (invol_grant == '0 && n < 8) begin
            step();
            n++;
        end
        chk(name, 32'(invol_grant != '0), 32'd1);
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] wr;
        logic [31:0]  d;
        logic         busy;
        logic [7:0]   space;
        logic [N-1:0] g;
        logic         w, e, a;
        logic [31:0]  md;
    } vec_t;

    function automatic vec_t mk(input logic [N-1:0] req, input logic [N-1:0] wr, input logic [31:0] d,
                                input logic busy, input logic [7:0] space, input logic [N-1:0] g,
                                input logic w, input logic e, input logic a, input logic [31:0] md);
        vec_t v;
        v.req = req; v.wr = wr; v.d = d; v.busy = busy; v.space = space;
        v.g = g; v.w = w; v.e = e; v.a = a; v.md = md;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[16];
        int   order[$];
        int   remaining[N];
        int   stage[N];
        int   n, nw, ne, na;
        logic [N-1:0] prev_g;

        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #12;
        chk("reset_grant", 32'(invol_grant), 32'd0);
        chk("reset_data", msg_data, 32'd0);
        chk("reset_write", 32'(msg_write), 32'd0);
        chk("reset_end", 32'(msg_end), 32'd0);
        chk("reset_abort", 32'(msg_abort), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unit 1 message, gating by cmd_busy/out_space, GAP spacing, end-with-write discard.
        tbl[0]  = mk(4'b0010, 4'b0000, 32'h0,        0, 8, 4'b0010, 0, 0, 0, 32'h0);
        tbl[1]  = mk(4'b0010, 4'b0010, 32'hA1A10001, 0, 8, 4'b0010, 1, 0, 0, 32'hA1A10001);
        tbl[2]  = mk(4'b0010, 4'b0010, 32'hB2B20002, 0, 8, 4'b0010, 1, 0, 0, 32'hB2B20002);
        tbl[3]  = mk(4'b0010, 4'b0010, 32'hC3C30003, 0, 8, 4'b0010, 1, 0, 0, 32'hC3C30003);
        tbl[4]  = mk(4'b0000, 4'b0000, 32'h21,       0, 8, 4'b0000, 0, 1, 0, 32'h21);
        tbl[5]  = mk(4'b0000, 4'b0000, 32'h0,        0, 8, 4'b0000, 0, 0, 0, 32'h21);
        tbl[6]  = mk(4'b0001, 4'b0000, 32'h0,        1, 8, 4'b0000, 0, 0, 0, 32'h21);
        tbl[7]  = mk(4'b0001, 4'b0000, 32'h0,        0, 7, 4'b0000, 0, 0, 0, 32'h21);
        tbl[8]  = mk(4'b0001, 4'b0000, 32'h0,        0, 8, 4'b0001, 0, 0, 0, 32'h21);
        tbl[9]  = mk(4'b0001, 4'b0001, 32'h77,       1, 0, 4'b0001, 1, 0, 0, 32'h77);
        tbl[10] = mk(4'b0000, 4'b0000, 32'h55,       0, 8, 4'b0000, 0, 1, 0, 32'h55);
        tbl[11] = mk(4'b0010, 4'b0000, 32'h0,        0, 8, 4'b0000, 0, 0, 0, 32'h55);
        tbl[12] = mk(4'b0010, 4'b0000, 32'h0,        0, 8, 4'b0010, 0, 0, 0, 32'h55);
        tbl[13] = mk(4'b0000, 4'b0010, 32'h99,       0, 8, 4'b0000, 0, 1, 0, 32'h99);
        tbl[14] = mk(4'b0000, 4'b0000, 32'h0,        0, 8, 4'b0000, 0, 0, 0, 32'h99);
        tbl[15] = mk(4'b0000, 4'b0000, 32'h0,        0, 8, 4'b0000, 0, 0, 0, 32'h99);
        for (int i = 0; i < 16; i++) begin
            invol_req = tbl[i].req; param_write = tbl[i].wr; param_data = {N{tbl[i].d}};
            cmd_busy = tbl[i].busy; out_space = tbl[i].space;
            step();
            chk($sformatf("tbl%0d_grant", i), 32'(invol_grant), 32'(tbl[i].g));
            chk($sformatf("tbl%0d_write", i), 32'(msg_write), 32'(tbl[i].w));
            chk($sformatf("tbl%0d_end", i), 32'(msg_end), 32'(tbl[i].e));
            chk($sformatf("tbl%0d_abort", i), 32'(msg_abort), 32'(tbl[i].a));
            chk($sformatf("tbl%0d_data", i), msg_data, tbl[i].md);
        end

        // Units 0,2,3 together, unit 0 repeats: expect 0,2,3,0.
        do_reset();
        remaining = '{2, 0, 1, 1};
        stage = '{0, 0, 0, 0};
        prev_g = '0;
        for (int c = 0; c < 60; c++) begin
            param_write = '0;
            for (int u = 0; u < N; u++) invol_req[u] = (remaining[u] > 0);
            param_data = {$urandom, $urandom, $urandom, $urandom};
            if (m_owner >= 0) begin
                if (stage[m_owner] == 0) begin
                    param_write[m_owner] = 1'b1; stage[m_owner] = 1;
                end else begin
                    invol_req[m_owner] = 1'b0; stage[m_owner] = 0; remaining[m_owner]--;
                end
            end
            step();
            if (prev_g == '0 && invol_grant != '0)
                for (int u = 0; u < N; u++) if (invol_grant[u]) order.push_back(u);
            prev_g = invol_grant;
        end
        chk("rr_order_len", 32'(order.size()), 32'd4);
        if (order.size() == 4) begin
            chk("rr_order0", 32'(order[0]), 32'd0);
            chk("rr_order1", 32'(order[1]), 32'd2);
            chk("rr_order2", 32'(order[2]), 32'd3);
            chk("rr_order3", 32'(order[3]), 32'd0);
        end

        // cmd_busy mid-message does not preempt.
        idle_inputs();
        invol_req = 4'b0010;
        wait_grant("busy_mid_granted");
        param_write = 4'b0010; param_data = {N{32'hDEAD0001}};
        step();
        cmd_busy = 1'b1; param_data = {N{32'hDEAD0002}};
        step();
        chk("busy_mid_grant_held", 32'(invol_grant), 32'h2);
        param_write = '0; invol_req = '0; param_data = {N{32'h31}};
        step();
        chk("busy_mid_end", 32'(msg_end), 32'd1);
        chk("busy_mid_code", msg_data, 32'h31);

        // Timeout: abort exactly TO cycles after grant.
        do_reset();
        invol_req = 4'b0001;
        step();
        n = 0;
        while (n < TO + 5) begin
            step();
            n++;
            if (msg_abort) break;
        end
        chk("timeout_cycle", 32'(n), 32'(TO));
        chk("timeout_grant_dropped", 32'(invol_grant), 32'd0);
`ifdef INVOL_ARBITER_STATS_EN
        chk("timeout_stat_aborts", 32'(stat_aborts), 32'd1);
`endif

        // Overflow: MW+1 writes -> MW write pulses then abort, no end.
        invol_req = '0;
        step(); step();
        invol_req = 4'b0100;
        wait_grant("ovf_granted");
        nw = 0; ne = 0; na = 0;
        param_write = 4'b0100;
        for (int i = 0; i < MW + 1; i++) begin
            param_data = {$urandom, $urandom, $urandom, $urandom};
            step();
            nw += int'(msg_write); ne += int'(msg_end); na += int'(msg_abort);
        end
        chk("ovf_writes", 32'(nw), 32'(MW));
        chk("ovf_abort_last", 32'(msg_abort), 32'd1);
        chk("ovf_aborts", 32'(na), 32'd1);
        chk("ovf_no_end", 32'(ne), 32'd0);
        param_write = '0; invol_req = '0;
        step(); step();

        // Async reset mid-message, then rr restarts at 0.
        do_reset();
        invol_req = 4'b0001;
        step();
        param_write = 4'b0001; param_data = {N{32'h1111}};
        step();
        param_data = {N{32'h2222}};
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_grant", 32'(invol_grant), 32'd0);
        chk("rst_mid_write", 32'(msg_write), 32'd0);
        chk("rst_mid_data", msg_data, 32'd0);
        chk("rst_mid_end", 32'(msg_end), 32'd0);
        chk("rst_mid_abort", 32'(msg_abort), 32'd0);
        model_reset();
        param_write = '0; invol_req = 4'b0101;
        #2 rst_n = 1'b1;
        step();
        chk("rst_rr_unit0", 32'(invol_grant), 32'h1);

        // Random traffic against the model.
        invol_req = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int u = 0; u < N; u++) begin
                if (invol_req[u]) begin
                    if ($urandom_range(0, 5) == 0) invol_req[u] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    invol_req[u] = 1'b1;
                end
                param_write[u] = ($urandom_range(0, 1) == 1);
            end
            param_data = {$urandom, $urandom, $urandom, $urandom};
            cmd_busy   = ($urandom_range(0, 4) == 0);
            out_space  = 8'($urandom_range(0, 12));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
